// File: rtl/rtc_bus_arbiter_if.sv
// Requester and RTC pin-side signals of the RTC bus arbiter, bundled for port use.
interface rtc_bus_arbiter_if;
  logic [2:0]  req;
  logic [2:0]  req_wr;
  logic [23:0] req_addr;
  logic [23:0] req_wdata;
  logic [2:0]  gnt;
  logic [2:0]  done;
  logic [7:0]  rd_data;
  logic        busy;
  logic [7:0]  bus_addr;
  logic [7:0]  bus_wdata;
  logic        bus_oe;
  logic        rd;
  logic        wr;
  logic [7:0]  bus_rdata;

  modport slave (
    input  req, req_wr, req_addr, req_wdata, bus_rdata,
    output gnt, done, rd_data, busy, bus_addr, bus_wdata, bus_oe, rd, wr
  );

  modport master (
    output req, req_wr, req_addr, req_wdata, bus_rdata,
    input  gnt, done, rd_data, busy, bus_addr, bus_wdata, bus_oe, rd, wr
  );
endinterface

// File: rtl/rtc_bus_arbiter.sv
// Round-robin arbiter for three RTC bus requesters; runs one address/strobe/hold/done
// bus cycle per grant and returns read data to the requesters.
module rtc_bus_arbiter #(
  parameter int ADDR_CYC   = 4,
  parameter int STROBE_CYC = 8,
  parameter int HOLD_CYC   = 2
) (
  input logic              clk,
  input logic              reset,
  rtc_bus_arbiter_if.slave io
);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_STROBE, S_HOLD, S_DONE} state_t;

  localparam logic [15:0] ADDR_LD   = 16'(ADDR_CYC - 1);
  localparam logic [15:0] STROBE_LD = 16'(STROBE_CYC - 1);
  localparam logic [15:0] HOLD_LD   = 16'(HOLD_CYC - 1);

  state_t      r_state, w_next;
  logic [15:0] r_cnt, w_cnt_nxt;
  logic [1:0]  r_rr;
  logic [2:0]  r_gnt;
  logic        r_is_wr;
  logic [7:0]  r_bus_addr, r_bus_wdata, r_rd_data;
  logic        r_bus_oe;
  logic        w_rd, w_wr, w_busy;
  logic [2:0]  w_done;
  logic [1:0]  w_pick;
  logic [2:0]  w_onehot;
  logic        w_sel_wr;
  logic [23:0] w_addr_sh, w_wdata_sh;

  // Search order is ptr+1, ptr+2, ptr so the last winner always ranks lowest.
  function automatic logic [1:0] rr_pick(input logic [1:0] ptr, input logic [2:0] r);
    logic [1:0] c;
    logic       found;
    rr_pick = ptr;
    found   = 1'b0;
    c       = ptr;
    for (int k = 0; k < 3; k++) begin
      c = (c == 2'd2) ? 2'd0 : c + 2'd1;
      if (!found && |(r & (3'b001 << c))) begin
        rr_pick = c;
        found   = 1'b1;
      end
    end
  endfunction

  assign w_pick     = rr_pick(r_rr, io.req);
  assign w_onehot   = 3'b001 << w_pick;
  assign w_sel_wr   = |(io.req_wr & w_onehot);
  assign w_addr_sh  = io.req_addr >> {w_pick, 3'b000};
  assign w_wdata_sh = io.req_wdata >> {w_pick, 3'b000};

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_cnt_nxt = r_cnt - 16'd1;
    w_rd      = 1'b0;
    w_wr      = 1'b0;
    w_busy    = 1'b1;
    w_done    = 3'b000;
    case (r_state)
      S_IDLE: begin
        w_busy    = 1'b0;
        w_cnt_nxt = r_cnt;
        if (io.req != 3'b000) begin
          w_next    = S_ADDR;
          w_cnt_nxt = ADDR_LD;
        end
      end
      S_ADDR: begin
        if (r_cnt == 16'd0) begin
          w_next    = S_STROBE;
          w_cnt_nxt = STROBE_LD;
        end
      end
      S_STROBE: begin
        w_rd = !r_is_wr;
        w_wr = r_is_wr;
        if (r_cnt == 16'd0) begin
          w_next    = S_HOLD;
          w_cnt_nxt = HOLD_LD;
        end
      end
      S_HOLD: begin
        if (r_cnt == 16'd0) begin
          w_next    = S_DONE;
          w_cnt_nxt = '0;
        end
      end
      S_DONE: begin
        w_done    = r_gnt;
        w_next    = S_IDLE;
        w_cnt_nxt = '0;
      end
      default: begin
        w_next    = S_IDLE;
        w_cnt_nxt = '0;
      end
    endcase
  end

  // Transaction is latched at grant; later requester changes cannot disturb the bus.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rr        <= 2'd2;
      r_gnt       <= '0;
      r_is_wr     <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_bus_oe    <= 1'b0;
      r_rd_data   <= '0;
    end else begin
      if (r_state == S_IDLE && io.req != 3'b000) begin
        r_rr        <= w_pick;
        r_gnt       <= w_onehot;
        r_is_wr     <= w_sel_wr;
        r_bus_addr  <= w_addr_sh[7:0];
        r_bus_wdata <= w_sel_wr ? w_wdata_sh[7:0] : 8'h00;
        r_bus_oe    <= w_sel_wr;
      end
      if (r_state == S_STROBE && r_cnt == 16'd0 && !r_is_wr)
        r_rd_data <= io.bus_rdata;
      if (r_state == S_HOLD && r_cnt == 16'd0) begin
        r_bus_addr  <= '0;
        r_bus_wdata <= '0;
        r_bus_oe    <= 1'b0;
      end
      if (r_state == S_DONE)
        r_gnt <= '0;
    end
  end

  assign io.gnt       = r_gnt;
  assign io.done      = w_done;
  assign io.rd_data   = r_rd_data;
  assign io.busy      = w_busy;
  assign io.bus_addr  = r_bus_addr;
  assign io.bus_wdata = r_bus_wdata;
  assign io.bus_oe    = r_bus_oe;
  assign io.rd        = w_rd;
  assign io.wr        = w_wr;

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// Bench for rtc_bus_arbiter: per-cycle transaction-level reference model, vector table,
// directed corner-case sequences and a randomized soak.
module tb_rtc_bus_arbiter;
  localparam int A = 4, S = 8, H = 2;
  localparam int TOT = A + S + H + 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  rtc_bus_arbiter_if bif();

  rtc_bus_arbiter #(.ADDR_CYC(A), .STROBE_CYC(S), .HOLD_CYC(H)) dut (
    .clk(clk), .reset(reset), .io(bif.slave)
  );

  always #5 clk = ~clk;

  // Reference: a transaction is "cycle m_t of TOT" since its grant; outputs follow from m_t.
  bit         m_act = 0;
  int         m_t = 0, m_sel = 0, m_rr = 2;
  logic       m_wr = 0;
  logic [7:0] m_addr = 0, m_wdata = 0, m_rdd = 0;

  typedef struct {
    logic [2:0]  req, req_wr;
    logic [23:0] addr, wdata;
    logic [7:0]  rdata;
    logic [2:0]  e_gnt;
    logic [7:0]  e_rdd;
    int          e_addr_cyc, e_oe_cyc, e_rd_cyc, e_wr_cyc;
  } vec_t;
  vec_t vt[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    if (!reset) begin
      m_act = 0; m_t = 0; m_rr = 2; m_rdd = 0;
    end else if (!m_act) begin
      if (bif.req != 3'b000) begin
        for (int k = 1; k <= 3; k++) begin
          if (!m_act && bif.req[(m_rr + k) % 3]) begin
            m_sel = (m_rr + k) % 3;
            m_act = 1;
          end
        end
        m_rr    = m_sel;
        m_wr    = bif.req_wr[m_sel];
        m_addr  = bif.req_addr[m_sel*8 +: 8];
        m_wdata = bif.req_wdata[m_sel*8 +: 8];
        m_t     = 1;
      end
    end else begin
      if (m_t == A + S && !m_wr) m_rdd = bif.bus_rdata;
      if (m_t == TOT) begin m_act = 0; m_t = 0; end
      else m_t++;
    end
  endtask

  task automatic check_outputs();
    bit drv, stb;
    logic [2:0] oh;
    drv = m_act && m_t <= A + S + H;
    stb = m_act && m_t > A && m_t <= A + S;
    oh  = m_act ? 3'(1 << m_sel) : 3'b000;
    chk("gnt", 32'(bif.gnt), 32'(oh));
    chk("done", 32'(bif.done), (m_act && m_t == TOT) ? 32'(oh) : 32'd0);
    chk("busy", 32'(bif.busy), 32'(m_act));
    chk("bus_addr", 32'(bif.bus_addr), drv ? 32'(m_addr) : 32'd0);
    chk("bus_wdata", 32'(bif.bus_wdata), (drv && m_wr) ? 32'(m_wdata) : 32'd0);
    chk("bus_oe", 32'(bif.bus_oe), 32'(drv && m_wr));
    chk("rd", 32'(bif.rd), 32'(stb && !m_wr));
    chk("wr", 32'(bif.wr), 32'(stb && m_wr));
    chk("rd_data", 32'(bif.rd_data), 32'(m_rdd));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic wait_gnt();
    int k = 0;
    while (bif.gnt == 3'b000 && k < 40) begin cyc(); k++; end
  endtask

  task automatic wait_done();
    int k = 0;
    while (bif.done == 3'b000 && k < 40) begin cyc(); k++; end
  endtask

  task automatic wait_rd();
    int k = 0;
    while (!bif.rd && k < 40) begin cyc(); k++; end
  endtask

  task automatic drain();
    int k = 0;
    bif.req = 3'b000;
    while (bif.busy && k < 40) begin cyc(); k++; end
    cyc();
  endtask

  task automatic reset_pulse();
    reset = 1'b0;
    cyc();
    reset = 1'b1;
  endtask

  task automatic run_vec(input vec_t v);
    int k, na, noe, nrd, nwr;
    bif.req = v.req; bif.req_wr = v.req_wr; bif.req_addr = v.addr;
    bif.req_wdata = v.wdata; bif.bus_rdata = v.rdata;
    cyc();
    wait_gnt();
    chk("vec_gnt", 32'(bif.gnt), 32'(v.e_gnt));
    bif.req = 3'b000;
    na = 0; noe = 0; nrd = 0; nwr = 0; k = 0;
    while (bif.done == 3'b000 && k < 40) begin
      na  += (bif.bus_addr != 8'h00) ? 1 : 0;
      noe += bif.bus_oe ? 1 : 0;
      nrd += bif.rd ? 1 : 0;
      nwr += bif.wr ? 1 : 0;
      cyc(); k++;
    end
    chk("vec_done", 32'(bif.done), 32'(v.e_gnt));
    cyc();
    chk("vec_rd_data", 32'(bif.rd_data), 32'(v.e_rdd));
    chk("vec_addr_cycles", 32'(na), 32'(v.e_addr_cyc));
    chk("vec_oe_cycles", 32'(noe), 32'(v.e_oe_cyc));
    chk("vec_rd_cycles", 32'(nrd), 32'(v.e_rd_cyc));
    chk("vec_wr_cycles", 32'(nwr), 32'(v.e_wr_cyc));
  endtask

  initial begin
    int idle;
    vt[0] = '{3'b001, 3'b000, 24'h000021, 24'h000000, 8'h59, 3'b001, 8'h59, 14, 0, 8, 0};
    vt[1] = '{3'b010, 3'b010, 24'h002200, 24'h004500, 8'hEE, 3'b010, 8'h59, 14, 14, 0, 8};
    vt[2] = '{3'b100, 3'b000, 24'h7F0000, 24'h000000, 8'hA3, 3'b100, 8'hA3, 14, 0, 8, 0};
    vt[3] = '{3'b001, 3'b001, 24'h000010, 24'h0000C3, 8'h11, 3'b001, 8'hA3, 14, 14, 0, 8};
    vt[4] = '{3'b100, 3'b100, 24'h300000, 24'h5A0000, 8'h22, 3'b100, 8'hA3, 14, 14, 0, 8};

    bif.req = 0; bif.req_wr = 0; bif.req_addr = 0; bif.req_wdata = 0; bif.bus_rdata = 8'hFF;
    @(negedge clk);
    cyc(); cyc();
    chk("reset_gnt", 32'(bif.gnt), 32'd0);
    chk("reset_busy", 32'(bif.busy), 32'd0);
    chk("reset_rd_data", 32'(bif.rd_data), 32'd0);
    reset = 1'b1;
    cyc();

    for (int i = 0; i < 5; i++) run_vec(vt[i]);

    // All three requesting continuously: strict rotation with one idle clock between.
    reset_pulse();
    bif.req = 3'b111; bif.req_wr = 3'b000; bif.req_addr = 24'h332211;
    cyc();
    for (int g = 0; g < 6; g++) begin
      chk("rr_order", 32'(bif.gnt), 32'(1 << (g % 3)));
      wait_done();
      chk("rr_done", 32'(bif.done), 32'(1 << (g % 3)));
      idle = 0;
      cyc();
      while (!bif.busy && idle < 10) begin idle++; cyc(); end
      chk("idle_gap", 32'(idle), 32'd1);
    end
    drain();

    // Requesters 1 and 2 arrive while 0 is on the bus.
    reset_pulse();
    bif.req = 3'b001;
    cyc();
    wait_gnt();
    chk("late_first", 32'(bif.gnt), 32'b001);
    cyc(); cyc();
    bif.req = 3'b110;
    wait_done();
    cyc();
    wait_gnt();
    chk("late_second", 32'(bif.gnt), 32'b010);
    wait_done();
    cyc();
    wait_gnt();
    chk("late_third", 32'(bif.gnt), 32'b100);
    drain();

    // Request withdrawn and address changed mid-strobe.
    bif.req = 3'b001; bif.req_wr = 3'b000; bif.req_addr = 24'h000021; bif.bus_rdata = 8'h5C;
    cyc();
    wait_gnt();
    wait_rd();
    bif.req = 3'b000; bif.req_addr = 24'h000099;
    cyc();
    chk("ignore_addr", 32'(bif.bus_addr), 32'h21);
    wait_done();
    chk("ignore_done", 32'(bif.done), 32'b001);
    cyc();
    chk("ignore_rd_data", 32'(bif.rd_data), 32'h5C);

    // Reset asserted during the strobe aborts the cycle.
    bif.req = 3'b001; bif.req_addr = 24'h000044; bif.bus_rdata = 8'h77;
    cyc();
    wait_gnt();
    wait_rd();
    reset = 1'b0;
    cyc();
    chk("abort_rd", 32'(bif.rd), 32'd0);
    chk("abort_gnt", 32'(bif.gnt), 32'd0);
    chk("abort_busy", 32'(bif.busy), 32'd0);
    chk("abort_done", 32'(bif.done), 32'd0);
    reset = 1'b1;
    cyc();
    wait_gnt();
    chk("after_abort_gnt", 32'(bif.gnt), 32'b001);
    wait_done();
    chk("after_abort_done", 32'(bif.done), 32'b001);
    drain();

    // Randomized soak against the model.
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 3) == 0) bif.req = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) begin
        bif.req_wr    = 3'($urandom);
        bif.req_addr  = 24'($urandom);
        bif.req_wdata = 24'($urandom);
      end
      bif.bus_rdata = 8'($urandom);
      reset = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      cyc();
    end
    reset = 1'b1;
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
